// File: rtl/edge_delay_meter_pkg.sv
// Shared state encoding and default sizing for the edge delay meter.
package edge_delay_meter_pkg;

    localparam int EDM_CNT_W   = 8;
    localparam int EDM_TIMEOUT = 200;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_DONE   = 2'd3
    } edm_state_t;

endpackage

// File: rtl/edm_counter.sv
// Compare-and-count datapath: counts WAIT edges and flags a response match
// or the last edge before the timeout limit.
module edm_counter
    import edge_delay_meter_pkg::*;
#(
    parameter int CNT_W   = EDM_CNT_W,
    parameter int TIMEOUT = EDM_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             enable,
    input  logic [1:0]       resp,
    input  logic [1:0]       expect_val,
    output logic [CNT_W-1:0] count,
    output logic             match,
    output logic             terminal
);

    localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] next_count;

    assign next_count = count + 1'b1;
    assign match      = (resp == expect_val);
    // Terminal fires on the edge that would bring the count up to TIMEOUT.
    assign terminal   = (next_count == TIMEOUT_V);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= next_count;
        end
    end

endmodule

// File: rtl/edge_delay_meter.sv
// Launches a stimulus word into a gate network and measures, in clock edges,
// how long the network takes to return the expected response.
module edge_delay_meter
    import edge_delay_meter_pkg::*;
#(
    parameter int CNT_W   = EDM_CNT_W,
    parameter int TIMEOUT = EDM_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       pattern_in,
    input  logic [1:0]       expect_in,
    output logic [2:0]       stim_out,
    input  logic [1:0]       resp_in,
    output logic             busy,
    output logic             done,
    output logic             timed_out,
    output logic [CNT_W-1:0] delay_cnt
);

    edm_state_t       state, state_nxt;
    logic [1:0]       exp_q;
    logic [CNT_W-1:0] cnt;
    logic             cnt_clear, cnt_en, match, terminal, accept, finish;

    edm_counter #(
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) u_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (cnt_clear),
        .enable     (cnt_en),
        .resp       (resp_in),
        .expect_val (exp_q),
        .count      (cnt),
        .match      (match),
        .terminal   (terminal)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        cnt_clear = 1'b1;
        cnt_en    = 1'b0;
        accept    = 1'b0;
        finish    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                busy      = 1'b1;
                state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                busy      = 1'b1;
                cnt_clear = 1'b0;
                cnt_en    = 1'b1;
                if (match || terminal) begin
                    finish    = 1'b1;
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // A match on the terminal edge still counts as a successful measurement.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stim_out  <= '0;
            exp_q     <= '0;
            delay_cnt <= '0;
            timed_out <= 1'b0;
        end else begin
            if (accept) begin
                stim_out  <= pattern_in;
                exp_q     <= expect_in;
                delay_cnt <= '0;
                timed_out <= 1'b0;
            end
            if (finish) begin
                delay_cnt <= cnt + 1'b1;
                timed_out <= ~match;
            end
        end
    end

endmodule

// File: tb/tb_edge_delay_meter.sv
// Directed bench for edge_delay_meter: a vector table of launches through
// loopback, delayed-network and stuck responses, plus hand-written corner cases.
module tb_edge_delay_meter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [2:0] pattern_in = 3'b000;
    logic [1:0] expect_in = 2'b00;
    logic [1:0] resp_const = 2'b00;
    int         mode = 0;

    logic [2:0] stim_a, stim_b;
    logic [1:0] resp_a, resp_b;
    logic       busy_a, done_a, to_a, busy_b, done_b, to_b;
    logic [7:0] dcnt_a, dcnt_b;
    logic [1:0] pa1, pa2, pa3, pa4, pb1, pb2, pb3, pb4;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    edge_delay_meter #(.CNT_W(8), .TIMEOUT(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .pattern_in(pattern_in),
        .expect_in(expect_in), .stim_out(stim_a), .resp_in(resp_a),
        .busy(busy_a), .done(done_a), .timed_out(to_a), .delay_cnt(dcnt_a)
    );

    edge_delay_meter #(.CNT_W(8), .TIMEOUT(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start), .pattern_in(pattern_in),
        .expect_in(expect_in), .stim_out(stim_b), .resp_in(resp_b),
        .busy(busy_b), .done(done_b), .timed_out(to_b), .delay_cnt(dcnt_b)
    );

    // Network under test: D = A&B | ~C, E = ~C, followed by a delay line.
    function automatic logic [1:0] net_f(input logic [2:0] s);
        return {(s[2] & s[1]) | ~s[0], ~s[0]};
    endfunction

    always @(posedge clk) begin
        pa1 <= net_f(stim_a); pa2 <= pa1; pa3 <= pa2; pa4 <= pa3;
        pb1 <= net_f(stim_b); pb2 <= pb1; pb3 <= pb2; pb4 <= pb3;
    end

    always_comb begin
        resp_a = resp_const;
        case (mode)
            0: resp_a = stim_a[1:0];
            1: resp_a = pa1;
            2: resp_a = pa2;
            3: resp_a = pa3;
            4: resp_a = pa4;
            default: resp_a = resp_const;
        endcase
    end

    always_comb begin
        resp_b = resp_const;
        case (mode)
            0: resp_b = stim_b[1:0];
            1: resp_b = pb1;
            2: resp_b = pb2;
            3: resp_b = pb3;
            4: resp_b = pb4;
            default: resp_b = resp_const;
        endcase
    end

    typedef struct {
        int         mode;
        logic [2:0] pat;
        logic [1:0] expv;
        logic [1:0] stuck;
        int         exp_delay;
        int         exp_to;
        int         exp_lat;
    } vec_t;

    vec_t vecs[8];

    task automatic check_output(input string name, input int actual, input int expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        start = 1'b0;
        repeat (5) next_cycle();
        rst_n = 1'b1;
    endtask

    // Presents a launch for exactly one edge (T0); returns at the negedge after T0.
    task automatic apply_stimulus(input logic [2:0] pat, input logic [1:0] expv);
        pattern_in = pat;
        expect_in  = expv;
        start      = 1'b1;
        next_cycle();
        start      = 1'b0;
    endtask

    // Counts edges from T0 (inclusive) until done is seen, bounded.
    task automatic wait_done(input bit use_b, output int lat);
        lat = 1;
        while (!(use_b ? done_b : done_a) && lat < 60) begin
            next_cycle();
            lat++;
        end
    endtask

    initial begin
        int lat;
        int ndone;
        bit pulse;

        vecs[0] = '{0, 3'b110, 2'b10, 2'b00, 1, 0, 3};
        vecs[1] = '{3, 3'b111, 2'b10, 2'b00, 3, 0, 5};
        vecs[2] = '{5, 3'b010, 2'b11, 2'b00, 16, 1, 18};
        vecs[3] = '{2, 3'b101, 2'b00, 2'b00, 2, 0, 4};
        vecs[4] = '{1, 3'b011, 2'b00, 2'b00, 1, 0, 3};
        vecs[5] = '{0, 3'b011, 2'b11, 2'b00, 1, 0, 3};
        vecs[6] = '{4, 3'b111, 2'b10, 2'b00, 4, 0, 6};
        vecs[7] = '{5, 3'b000, 2'b01, 2'b01, 1, 0, 3};

        do_reset();
        check_output("reset stim_out", int'(stim_a), 0);
        check_output("reset delay_cnt", int'(dcnt_a), 0);
        check_output("reset timed_out", int'(to_a), 0);
        check_output("reset done", int'(done_a), 0);
        check_output("reset busy", int'(busy_a), 0);

        for (int i = 0; i < 8; i++) begin
            mode       = vecs[i].mode;
            resp_const = vecs[i].stuck;
            do_reset();
            apply_stimulus(vecs[i].pat, vecs[i].expv);
            check_output($sformatf("v%0d busy after start", i), int'(busy_a), 1);
            check_output($sformatf("v%0d stim_out launch", i), int'(stim_a), int'(vecs[i].pat));
            wait_done(1'b0, lat);
            check_output($sformatf("v%0d latency", i), lat, vecs[i].exp_lat);
            check_output($sformatf("v%0d delay_cnt", i), int'(dcnt_a), vecs[i].exp_delay);
            check_output($sformatf("v%0d timed_out", i), int'(to_a), vecs[i].exp_to);
            next_cycle();
            check_output($sformatf("v%0d done width", i), int'(done_a), 0);
            check_output($sformatf("v%0d busy idle", i), int'(busy_a), 0);
            check_output($sformatf("v%0d stim_out hold", i), int'(stim_a), int'(vecs[i].pat));
            check_output($sformatf("v%0d delay hold", i), int'(dcnt_a), vecs[i].exp_delay);
        end

        // Restart while busy and in DONE, with expect_in changing during WAIT.
        mode = 3;
        do_reset();
        apply_stimulus(3'b111, 2'b10);
        pattern_in = 3'b000;
        expect_in  = 2'b11;
        start      = 1'b1;
        ndone      = 0;
        pulse      = 1'b0;
        for (int c = 1; c <= 25; c++) begin
            next_cycle();
            if (c == 3) start = 1'b0;
            if (pulse) begin
                start = 1'b0;
                pulse = 1'b0;
            end
            if (done_a) begin
                ndone++;
                if (ndone == 1) begin
                    start = 1'b1;
                    pulse = 1'b1;
                end
            end
        end
        check_output("busy-restart done count", ndone, 1);
        check_output("busy-restart delay_cnt", int'(dcnt_a), 3);
        check_output("busy-restart timed_out", int'(to_a), 0);
        check_output("busy-restart stim_out", int'(stim_a), 7);

        // Reset mid-WAIT at counter 5, with start held during the reset edge.
        mode       = 5;
        resp_const = 2'b00;
        do_reset();
        apply_stimulus(3'b010, 2'b11);
        repeat (6) next_cycle();
        rst_n = 1'b0;
        start = 1'b1;
        next_cycle();
        rst_n = 1'b1;
        start = 1'b0;
        check_output("midwait reset stim_out", int'(stim_a), 0);
        check_output("midwait reset delay_cnt", int'(dcnt_a), 0);
        check_output("midwait reset timed_out", int'(to_a), 0);
        check_output("midwait reset done", int'(done_a), 0);
        check_output("midwait reset busy", int'(busy_a), 0);
        ndone = 0;
        for (int c = 0; c < 20; c++) begin
            next_cycle();
            if (done_a) ndone++;
        end
        check_output("midwait no done", ndone, 0);
        mode = 0;
        apply_stimulus(3'b110, 2'b10);
        wait_done(1'b0, lat);
        check_output("post-reset latency", lat, 3);
        check_output("post-reset delay_cnt", int'(dcnt_a), 1);

        // timed_out is held after a timeout and cleared by the next accepted start.
        mode       = 5;
        resp_const = 2'b00;
        do_reset();
        apply_stimulus(3'b010, 2'b11);
        wait_done(1'b0, lat);
        repeat (5) next_cycle();
        check_output("timeout held", int'(to_a), 1);
        check_output("timeout delay held", int'(dcnt_a), 16);
        mode = 0;
        apply_stimulus(3'b110, 2'b10);
        check_output("restart clears timed_out", int'(to_a), 0);
        check_output("restart clears delay_cnt", int'(dcnt_a), 0);
        wait_done(1'b0, lat);
        check_output("restart delay_cnt", int'(dcnt_a), 1);

        // TIMEOUT=4 instance: match on the terminal edge wins, else timeout.
        mode = 4;
        do_reset();
        apply_stimulus(3'b111, 2'b10);
        wait_done(1'b1, lat);
        check_output("t4 match latency", lat, 6);
        check_output("t4 match delay_cnt", int'(dcnt_b), 4);
        check_output("t4 match timed_out", int'(to_b), 0);
        mode       = 5;
        resp_const = 2'b00;
        do_reset();
        apply_stimulus(3'b010, 2'b11);
        wait_done(1'b1, lat);
        check_output("t4 abort latency", lat, 6);
        check_output("t4 abort delay_cnt", int'(dcnt_b), 4);
        check_output("t4 abort timed_out", int'(to_b), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/edge_delay_meter.md
EDGE_DELAY_METER -- requirements
Module: edge_delay_meter

Interface
REQ-001 SHALL have parameter CNT_W, 8, delay counter width in bits.
REQ-002 SHALL have parameter TIMEOUT, 200, maximum edges waited before abort; legal range 1..2^CNT_W-1.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port start  input  1  launch request, sampled only in IDLE.
REQ-006 SHALL have port pattern_in  input  3  stimulus word {A,B,C} to launch.
REQ-007 SHALL have port expect_in  input  2  expected response {D,E}.
REQ-008 SHALL have port stim_out  output  3  registered stimulus {A,B,C} driven to the gate network under test.
REQ-009 SHALL have port resp_in  input  2  response {D,E} returned from the network; synchronous to clk.
REQ-010 SHALL have port busy  output  1  high in LAUNCH and WAIT.
REQ-011 SHALL have port done  output  1  one-cycle pulse when a measurement completes.
REQ-012 SHALL have port timed_out  output  1  high when the last measurement aborted; held until next accepted start.
REQ-013 SHALL have port delay_cnt  output  CNT_W  measured delay in clock edges; held until next accepted start.

Function
REQ-014 SHALL implement FSM states IDLE, LAUNCH, WAIT, DONE.
REQ-015 IDLE: start=1 at edge T0 SHALL latch pattern_in and expect_in, go to LAUNCH, clear delay_cnt and timed_out.
REQ-016 LAUNCH (one cycle, after T0): stim_out SHALL equal latched pattern; internal counter cleared to 0; next state WAIT.
REQ-017 WAIT: at each edge, counter SHALL increment by 1; if resp_in equals latched expect, delay_cnt <= counter+1, go to DONE.
REQ-018 WAIT: if counter+1 equals TIMEOUT with no match, delay_cnt <= TIMEOUT, timed_out <= 1, go to DONE.
REQ-019 Match and timeout on the same edge: match SHALL win; timed_out stays 0.
REQ-020 DONE: done SHALL be 1 for exactly one cycle; next state IDLE unconditionally.
REQ-021 start while busy or in DONE SHALL be ignored; no queuing.
REQ-022 A network with zero cycles of delay (combinational loopback) SHALL yield delay_cnt=1.
REQ-023 stim_out SHALL hold the launched pattern after completion until the next LAUNCH.
REQ-024 Counter SHALL never wrap; TIMEOUT bounds it below 2^CNT_W.
REQ-025 Latched expect SHALL not change during WAIT regardless of expect_in.

Reset
REQ-026 rst_n=0 at an edge SHALL force state IDLE, stim_out=0, delay_cnt=0, timed_out=0, done=0, busy=0, counter=0.
REQ-027 Reset in any state, including mid-WAIT, SHALL abort with no done pulse.
REQ-028 start coincident with rst_n=0 SHALL be ignored.

Structure
REQ-029 FSM state encoding and default CNT_W/TIMEOUT SHALL live in shared package edge_delay_meter_pkg.
REQ-030 The compare-and-count datapath SHALL be sub-module edm_counter (clear, enable, count, terminal flag); FSM stays in edge_delay_meter.

Verification
REQ-031 Loopback resp_in=stim_out[1:0], pattern=3'b110, expect=2'b10, start pulse -> done 3 edges after start, delay_cnt=1, timed_out=0.
REQ-032 Behavioural network with 3-cycle delay (D=A&B|~C, E=~C), pattern=3'b111, expect=2'b10 -> delay_cnt=3, timed_out=0.
REQ-033 TIMEOUT=16, resp_in stuck 2'b00, expect=2'b11 -> delay_cnt=16, timed_out=1, single done pulse.
REQ-034 Second start asserted while busy -> ignored; exactly one done; delay_cnt from first launch.
REQ-035 rst_n low for one cycle in WAIT at counter=5 -> no done, all outputs 0 next cycle, fresh start measures correctly.
REQ-036 TIMEOUT=4, response matches on 4th WAIT edge -> delay_cnt=4, timed_out=0.
